// File: rtl/upc_tag_serializer.sv
// Bit-serial transmitter for one {U,P,C,M} item tag: start, four data bits, parity, stop,
// each bit held BIT_CYCLES clocks; tags are taken on a valid/ready handshake.
module upc_tag_serializer #(
    parameter int unsigned BIT_CYCLES = 4,
    parameter bit          PARITY_ODD = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic U,
    input  logic P,
    input  logic C,
    input  logic M,
    input  logic valid,
    output logic ready,
    output logic tx,
    output logic busy,
    output logic done
);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    localparam logic [7:0] LAST_CYC = 8'(BIT_CYCLES - 1);

    state_t     state_q, state_d;
    logic [7:0] cyc_q, cyc_d;
    logic [1:0] bit_q, bit_d;
    logic [3:0] tag_q, tag_d;
    logic       tx_q, tx_d;
    logic       ready_q, ready_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       last_cyc;
    logic       take;
    logic       parity;

    assign last_cyc = (cyc_q == LAST_CYC);
    assign parity   = (^tag_q) ^ PARITY_ODD;

    // A waiting tag is chained straight off the final stop cycle so frames run back-to-back.
    assign take = valid && ((state_q == IDLE) || ((state_q == STOP) && last_cyc));

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        bit_d   = bit_q;
        tag_d   = tag_q;
        tx_d    = tx_q;
        ready_d = ready_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        if (state_q != IDLE) begin
            cyc_d = last_cyc ? 8'd0 : cyc_q + 8'd1;
        end

        case (state_q)
            START: begin
                if (last_cyc) begin
                    state_d = DATA;
                    bit_d   = 2'd0;
                    tx_d    = tag_q[3];
                end
            end
            DATA: begin
                if (last_cyc) begin
                    if (bit_q == 2'd3) begin
                        state_d = PARITY;
                        tx_d    = parity;
                    end else begin
                        bit_d = bit_q + 2'd1;
                        tx_d  = tag_q[2'd2 - bit_q];
                    end
                end
            end
            PARITY: begin
                if (last_cyc) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end
            STOP: begin
                if (last_cyc) begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                    tx_d    = 1'b1;
                    done_d  = 1'b1;
                end
            end
            default: begin
                cyc_d = 8'd0;
            end
        endcase

        if (take) begin
            state_d = START;
            tag_d   = {U, P, C, M};
            cyc_d   = 8'd0;
            bit_d   = 2'd0;
            tx_d    = 1'b0;
            ready_d = 1'b0;
            busy_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cyc_q   <= 8'd0;
            bit_q   <= 2'd0;
            tag_q   <= 4'd0;
            tx_q    <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            bit_q   <= bit_d;
            tag_q   <= tag_d;
            tx_q    <= tx_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign ready = ready_q;
    assign tx    = tx_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_upc_tag_serializer.sv
// Bench for upc_tag_serializer: three configurations share one stimulus stream and are
// checked every cycle against a frame-position model plus literal tx sequences.
module tb_upc_tag_serializer;

    localparam int BC[3] = '{4, 4, 1};
    localparam bit PO[3] = '{1'b0, 1'b1, 1'b0};

    logic clk;
    logic reset;
    logic U, P, C, M, valid;
    logic txW[3];
    logic readyW[3];
    logic busyW[3];
    logic doneW[3];

    int total = 0;
    int bad   = 0;

    bit         mBusy[3];
    int         mPos[3];
    bit         mDone[3];
    logic [6:0] mFrm[3];

    upc_tag_serializer #(.BIT_CYCLES(4), .PARITY_ODD(1'b0)) dut0 (
        .clk(clk), .reset(reset), .U(U), .P(P), .C(C), .M(M), .valid(valid),
        .ready(readyW[0]), .tx(txW[0]), .busy(busyW[0]), .done(doneW[0])
    );
    upc_tag_serializer #(.BIT_CYCLES(4), .PARITY_ODD(1'b1)) dut1 (
        .clk(clk), .reset(reset), .U(U), .P(P), .C(C), .M(M), .valid(valid),
        .ready(readyW[1]), .tx(txW[1]), .busy(busyW[1]), .done(doneW[1])
    );
    upc_tag_serializer #(.BIT_CYCLES(1), .PARITY_ODD(1'b0)) dut2 (
        .clk(clk), .reset(reset), .U(U), .P(P), .C(C), .M(M), .valid(valid),
        .ready(readyW[2]), .tx(txW[2]), .busy(busyW[2]), .done(doneW[2])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // The model tracks only "cycles since accept" and the 7-bit frame; tx is frame[pos / BC].
    initial begin
        for (int k = 0; k < 3; k++) begin
            mBusy[k] = 1'b0;
            mPos[k]  = 0;
            mDone[k] = 1'b0;
            mFrm[k]  = 7'h7f;
        end
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < 3; k++) begin
                mBusy[k] <= 1'b0;
                mPos[k]  <= 0;
                mDone[k] <= 1'b0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                mDone[k] <= mBusy[k] && (mPos[k] == 7 * BC[k] - 1);
                if (mBusy[k] && (mPos[k] != 7 * BC[k] - 1)) begin
                    mPos[k] <= mPos[k] + 1;
                end else if (valid) begin
                    mBusy[k] <= 1'b1;
                    mPos[k]  <= 0;
                    mFrm[k]  <= {1'b1, U ^ P ^ C ^ M ^ PO[k], M, C, P, U, 1'b0};
                end else begin
                    mBusy[k] <= 1'b0;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [6:0] act, input logic [6:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] tag, input logic v);
        {U, P, C, M} = tag;
        valid = v;
    endtask

    // Samples tx at the first cycle of each bit, starting at the cycle right after accept.
    task automatic captureFrame(input int k, input int bc, output logic [6:0] seq);
        seq = '0;
        for (int c = 0; c < 7 * bc; c++) begin
            if (c % bc == 0) seq[6 - c / bc] = txW[k];
            @(negedge clk);
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("cyc tx[%0d]", k), {6'd0, txW[k]},
                        {6'd0, mBusy[k] ? mFrm[k][mPos[k] / BC[k]] : 1'b1});
            checkOutput($sformatf("cyc ready[%0d]", k), {6'd0, readyW[k]}, {6'd0, !mBusy[k]});
            checkOutput($sformatf("cyc busy[%0d]", k), {6'd0, busyW[k]}, {6'd0, mBusy[k]});
            checkOutput($sformatf("cyc done[%0d]", k), {6'd0, doneW[k]}, {6'd0, mDone[k]});
        end
    end

    initial begin
        logic [6:0] s0, s1;
        reset = 1'b1;
        applyStimulus(4'b0000, 1'b0);
        #2 reset = 1'b0;
        #1;
        checkOutput("reset tx", {6'd0, txW[0]}, 7'd1);
        checkOutput("reset ready", {6'd0, readyW[0]}, 7'd1);
        checkOutput("reset busy", {6'd0, busyW[0]}, 7'd0);
        checkOutput("reset done", {6'd0, doneW[0]}, 7'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        $display("[TB] even/odd parity, tag 1010");
        applyStimulus(4'b1010, 1'b1);
        @(negedge clk);
        applyStimulus(4'b1010, 1'b0);
        fork
            captureFrame(0, 4, s0);
            captureFrame(1, 4, s1);
        join
        checkOutput("t1 even seq", s0, 7'b0101001);
        checkOutput("t1 odd seq", s1, 7'b0101011);
        checkOutput("t1 done at 28", {6'd0, doneW[0]}, 7'd1);
        checkOutput("t1 ready after", {6'd0, readyW[0]}, 7'd1);

        $display("[TB] tag 1011 and 0000");
        applyStimulus(4'b1011, 1'b1);
        @(negedge clk);
        applyStimulus(4'b1011, 1'b0);
        fork
            captureFrame(0, 4, s0);
            captureFrame(1, 4, s1);
        join
        checkOutput("t2 even 1011", s0, 7'b0101111);
        checkOutput("t2 odd 1011", s1, 7'b0101101);
        applyStimulus(4'b0000, 1'b1);
        @(negedge clk);
        applyStimulus(4'b0000, 1'b0);
        fork
            captureFrame(0, 4, s0);
            captureFrame(1, 4, s1);
        join
        checkOutput("t2 even 0000", s0, 7'b0000001);
        checkOutput("t2 odd 0000", s1, 7'b0000011);

        $display("[TB] back-to-back 1100 then 0011");
        applyStimulus(4'b1100, 1'b1);
        @(negedge clk);
        applyStimulus(4'b0011, 1'b1);
        captureFrame(0, 4, s0);
        checkOutput("t3 first seq", s0, 7'b0110001);
        checkOutput("t3 done chained", {6'd0, doneW[0]}, 7'd1);
        checkOutput("t3 no gap tx", {6'd0, txW[0]}, 7'd0);
        checkOutput("t3 ready low", {6'd0, readyW[0]}, 7'd0);
        applyStimulus(4'b0011, 1'b0);
        captureFrame(0, 4, s0);
        checkOutput("t3 second seq", s0, 7'b0001101);
        checkOutput("t3 second done", {6'd0, doneW[0]}, 7'd1);

        $display("[TB] mid-frame input changes ignored");
        applyStimulus(4'b1111, 1'b1);
        @(negedge clk);
        applyStimulus(4'b1111, 1'b0);
        fork
            captureFrame(0, 4, s0);
            begin
                repeat (5) @(negedge clk);
                applyStimulus(4'b0000, 1'b1);
                @(negedge clk);
                applyStimulus(4'b0101, 1'b0);
                repeat (8) @(negedge clk);
                applyStimulus(4'b1010, 1'b1);
                @(negedge clk);
                applyStimulus(4'b0011, 1'b0);
            end
        join
        checkOutput("t4 seq", s0, 7'b0111101);
        checkOutput("t4 done", {6'd0, doneW[0]}, 7'd1);
        repeat (10) @(negedge clk);
        checkOutput("t4 no extra frame", {6'd0, busyW[0]}, 7'd0);

        $display("[TB] reset during second data bit");
        applyStimulus(4'b0101, 1'b1);
        @(negedge clk);
        applyStimulus(4'b0101, 1'b0);
        repeat (9) @(negedge clk);
        checkOutput("t5 busy before", {6'd0, busyW[0]}, 7'd1);
        #2 reset = 1'b0;
        #1;
        checkOutput("t5 async tx", {6'd0, txW[0]}, 7'd1);
        checkOutput("t5 async ready", {6'd0, readyW[0]}, 7'd1);
        checkOutput("t5 async busy", {6'd0, busyW[0]}, 7'd0);
        repeat (2) @(negedge clk);
        checkOutput("t5 no done", {6'd0, doneW[0]}, 7'd0);
        applyStimulus(4'b1001, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("t5 accept busy", {6'd0, busyW[0]}, 7'd1);
        applyStimulus(4'b1001, 1'b0);
        captureFrame(0, 4, s0);
        checkOutput("t5 new frame", s0, 7'b0100101);

        $display("[TB] BIT_CYCLES=1, tag 0110");
        applyStimulus(4'b0110, 1'b1);
        @(negedge clk);
        applyStimulus(4'b0110, 1'b0);
        captureFrame(2, 1, s0);
        checkOutput("t6 seq", s0, 7'b0011001);
        checkOutput("t6 done at 7", {6'd0, doneW[2]}, 7'd1);
        repeat (30) @(negedge clk);
        checkOutput("t6 all idle", {6'd0, busyW[0]}, 7'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/upc_tag_serializer.md
Name: upc_tag_serializer

Overview:
- Transmit-side counterpart to the checkout marker logic: takes one parallel item tag {U, P, C, M} (UPC digits U/P/C plus mark bit M) and sends it as a framed bit-serial stream on a single tag line.
- The reader at the register/scanner end decodes this stream back into U, P, C, M for the discount/stolen logic.
- Sits between the item-entry switches/controller and the tag line; accepts one tag per valid/ready handshake.

Parameters:
BIT_CYCLES, 4, clock cycles per serial bit; legal range 1..255.
PARITY_ODD, 0, 0 = even parity over the 4 data bits, 1 = odd parity.

Ports:
clk  input  1  system clock; all state changes on rising edge.
reset  input  1  asynchronous, active-low reset; 0 = reset asserted.
U  input  1  tag data bit, sent first.
P  input  1  tag data bit, sent second.
C  input  1  tag data bit, sent third.
M  input  1  mark bit, sent fourth.
valid  input  1  {U,P,C,M} holds a tag to send.
ready  output  1  block can accept a tag this cycle.
tx  output  1  serial tag line; idles high.
busy  output  1  a frame is in progress.
done  output  1  one-cycle pulse when a frame finishes.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, tx=1, ready=1, busy=0, done=0; cycle and bit counters cleared; latched tag cleared.
- All outputs are registered; no combinational path from inputs to outputs.
- Frame format: 7 bits, each held exactly BIT_CYCLES cycles, in this order:
  - start (0);
  - data U, P, C, M;
  - parity: U^P^C^M, XORed with PARITY_ODD;
  - stop (1).
- Frame length is 7*BIT_CYCLES cycles.
- States: IDLE -> START -> DATA -> PARITY -> STOP -> IDLE.
  - Each state lasts BIT_CYCLES cycles.
  - DATA repeats for 4 bits; the bit index runs 0..3 and advances on cycle-counter wrap.
- Handshake:
  - ready=1 only in IDLE.
  - A tag is accepted at a rising edge where valid=1 and ready=1; {U,P,C,M} is latched at that edge.
  - On that same edge: ready goes 0, busy goes 1, tx goes 0 (start bit begins).
- Inputs are ignored while busy=1. Changes on U/P/C/M or valid mid-frame do not affect the frame in flight.
- Completion:
  - At the edge ending the last stop-bit cycle, the state returns to IDLE with ready=1, busy=0, tx=1, done=1.
  - done stays high for exactly one cycle.
- Back-to-back: if valid=1 during the done cycle, the next tag is accepted on that edge. The next start bit follows the previous stop bit with zero idle cycles.
- BIT_CYCLES=1: each bit lasts one cycle and the frame is 7 cycles. Behaviour is otherwise identical.
- Reset mid-frame aborts the frame: tx returns to 1 immediately (asynchronously), no done pulse, and the latched tag is discarded.
- After reset deasserts, the first rising edge may accept a tag.

Test Plan:
1. BIT_CYCLES=4, PARITY_ODD=0; accept {U,P,C,M}=1010 -> tx holds 0,1,0,1,0,0,1 for 4 cycles each (parity 0); done pulses 28 cycles after the accept edge; ready=0 throughout the frame.
2. Even parity, tag 1011 -> parity bit 1; odd parity (PARITY_ODD=1), tag 1010 -> parity bit 1; tag 0000 with odd parity -> tx 0,0,0,0,0,1,1.
3. valid held high with tags 1100 then 0011 -> two frames of 28 cycles each with no idle gap; second tag latched in the done cycle; done pulses twice.
4. Accept 1111, then toggle U/P/C/M and pulse valid mid-frame -> serial data stays 1,1,1,1 with parity 0; no extra frame is sent.
5. Drop reset during the second data bit -> tx=1, ready=1, busy=0 immediately with no clock edge; no done; a new tag is accepted on the first edge after release.
6. BIT_CYCLES=1, tag 0110 -> tx sequence 0,0,1,1,0,0,1 over 7 consecutive cycles; done on the 7th edge after accept.
